// File: rtl/div_result_buffer.sv
// Result buffer behind pipeline_division: stores every quotient/remainder pair
// in a FIFO and hands it to the consumer over ready/valid. The divider cannot be
// stalled, so in-flight divisions are counted and issue_ok_o is raised only while
// a FIFO slot is guaranteed for every outstanding result.
module div_result_buffer #(
  parameter int unsigned QUOTIENT_WIDTH = 8,
  parameter int unsigned REMINDER_WIDTH = 8,
  parameter int unsigned DEPTH          = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         issue_i,
  output logic                         issue_ok_o,
  input  logic                         valid_i,
  input  logic [QUOTIENT_WIDTH-1:0]    quotient_i,
  input  logic [REMINDER_WIDTH-1:0]    reminder_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [QUOTIENT_WIDTH-1:0]    quotient_o,
  output logic [REMINDER_WIDTH-1:0]    reminder_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         error_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);

  logic [QUOTIENT_WIDTH-1:0] q_mem [DEPTH];
  logic [REMINDER_WIDTH-1:0] r_mem [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] inflight_q, inflight_d;
  logic            error_q, error_d;

  logic            full, pop, push, issue_ok;
  logic [CntW:0]   credit_sum;

  assign full       = (count_q == DepthC);
  assign valid_o    = (count_q != '0);
  assign pop        = valid_o & ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push       = valid_i & (~full | pop);
  assign credit_sum = {1'b0, count_q} + {1'b0, inflight_q};
  assign issue_ok   = (credit_sum < {1'b0, DepthC});

  assign issue_ok_o = issue_ok;
  assign count_o    = count_q;
  assign error_o    = error_q;
  assign quotient_o = valid_o ? q_mem[rd_ptr_q] : '0;
  assign reminder_o = valid_o ? r_mem[rd_ptr_q] : '0;

  // Next-state for pointers, fill level, in-flight credit and the sticky error.
  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PtrOne : rd_ptr_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    error_d    = error_q;

    case ({push, pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase

    // Issue and result together leave the in-flight count unchanged.
    if (issue_i && !valid_i) begin
      if (inflight_q != DepthC) inflight_d = inflight_q + CntOne;
    end else if (!issue_i && valid_i) begin
      if (inflight_q != '0) inflight_d = inflight_q - CntOne;
    end

    if (valid_i && full && !pop)                  error_d = 1'b1;
    if (issue_i && !issue_ok)                     error_d = 1'b1;
    // A result with nothing outstanding (and no zero-latency issue) is unexpected.
    if (valid_i && !issue_i && inflight_q == '0)  error_d = 1'b1;
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      error_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      error_q    <= error_d;
    end
  end

  // Storage array, written on push; contents are not reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      q_mem[wr_ptr_q] <= quotient_i;
      r_mem[wr_ptr_q] <= reminder_i;
    end
  end

endmodule

// File: tb/tb_div_result_buffer.sv
// Bench for div_result_buffer (DEPTH 8): directed vector table, random ordered
// stream against a fixed-latency divider model, and reset/violation sequences.
module tb_div_result_buffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       issue_i, valid_i, ready_i;
  logic [7:0] quotient_i, reminder_i;
  logic       issue_ok_o, valid_o, error_o;
  logic [7:0] quotient_o, reminder_o;
  logic [3:0] count_o;

  int applied = 0;
  int miscompares = 0;

  div_result_buffer #(
    .QUOTIENT_WIDTH(8),
    .REMINDER_WIDTH(8),
    .DEPTH(8)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .issue_i(issue_i),
    .issue_ok_o(issue_ok_o),
    .valid_i(valid_i),
    .quotient_i(quotient_i),
    .reminder_i(reminder_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .quotient_o(quotient_o),
    .reminder_o(reminder_o),
    .count_o(count_o),
    .error_o(error_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       issue;
    logic       valid;
    logic       ready;
    logic [7:0] q;
    logic [7:0] r;
    logic       ev;
    logic [7:0] eq;
    logic [7:0] er;
    logic [3:0] ecnt;
    logic       eok;
    logic       eerr;
  } vec_t;

  typedef struct packed {
    logic       v;
    logic [7:0] q;
    logic [7:0] r;
  } stage_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic is, input logic va, input logic rd,
                              input logic [7:0] q, input logic [7:0] r,
                              input logic ev, input logic [7:0] eq, input logic [7:0] er,
                              input logic [3:0] ecnt, input logic eok, input logic eerr);
    vec_t v;
    v.issue = is; v.valid = va; v.ready = rd; v.q = q; v.r = r;
    v.ev = ev; v.eq = eq; v.er = er; v.ecnt = ecnt; v.eok = eok; v.eerr = eerr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    quotient_i = '0; reminder_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    #3;
    step();
    rst_n = 1'b1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"}, 32'(valid_o), 0);
    chk({tag, ".count"}, 32'(count_o), 0);
    chk({tag, ".ok"}, 32'(issue_ok_o), 1);
    chk({tag, ".err"}, 32'(error_o), 0);
    chk({tag, ".q"}, 32'(quotient_o), 0);
    chk({tag, ".r"}, 32'(reminder_o), 0);
  endtask

  initial begin
    stage_t     pipe [3];
    logic [15:0] expq[$];
    logic [15:0] head;
    int popped, issued, cyc;
    logic [7:0] nq, nr;

    do_reset();
    chk_idle("reset");

    // Single result, then credit exhaustion, then full push+pop and drain.
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 25, 3, 1, 25, 3, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, logic'(i < 7), 0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, 1, 0, 8'(10 + i), 8'(i), 1, 10, 0, 4'(i + 1), 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 11, 1, 7, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 11, 1, 7, 0, 0));
    // Issue without credit: error raised, inflight goes to 2.
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 11, 1, 7, 0, 1));
    vecs.push_back(mk(0, 1, 0, 50, 5, 1, 11, 1, 8, 0, 1));
    // Full FIFO, push and pop together: count stays 8, head advances.
    vecs.push_back(mk(0, 1, 1, 51, 6, 1, 12, 2, 8, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 13, 3, 7, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 14, 4, 6, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 15, 5, 5, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 16, 6, 4, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 17, 7, 3, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 50, 5, 2, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 51, 6, 1, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1));

    foreach (vecs[i]) begin
      issue_i = vecs[i].issue; valid_i = vecs[i].valid; ready_i = vecs[i].ready;
      quotient_i = vecs[i].q; reminder_i = vecs[i].r;
      step();
      chk($sformatf("v%0d.valid", i), 32'(valid_o), 32'(vecs[i].ev));
      chk($sformatf("v%0d.q", i), 32'(quotient_o), 32'(vecs[i].eq));
      chk($sformatf("v%0d.r", i), 32'(reminder_o), 32'(vecs[i].er));
      chk($sformatf("v%0d.count", i), 32'(count_o), 32'(vecs[i].ecnt));
      chk($sformatf("v%0d.ok", i), 32'(issue_ok_o), 32'(vecs[i].eok));
      chk($sformatf("v%0d.err", i), 32'(error_o), 32'(vecs[i].eerr));
    end

    // Random ordered stream through a 3-cycle divider model.
    do_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    popped = 0; issued = 0; cyc = 0;
    while (popped < 100 && cyc < 5000) begin
      ready_i = 1'($urandom_range(0, 1));
      if (ready_i && valid_o) begin
        if (expq.size() == 0) begin
          chk("stream.unexpected_pop", 32'(count_o), 0);
        end else begin
          head = expq.pop_front();
          chk($sformatf("stream%0d.data", popped), {16'h0, quotient_o, reminder_o},
              {16'h0, head});
        end
        popped++;
      end
      valid_i = pipe[2].v; quotient_i = pipe[2].q; reminder_i = pipe[2].r;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      issue_i = issue_ok_o && issued < 100 && $urandom_range(0, 3) != 0;
      if (issue_i) begin
        nq = 8'($urandom); nr = 8'($urandom);
        expq.push_back({nq, nr});
        pipe[0] = {1'b1, nq, nr};
        issued++;
      end else begin
        pipe[0] = '0;
      end
      step();
      cyc++;
    end
    idle_inputs();
    chk("stream.popped", 32'(popped), 100);
    chk("stream.err", 32'(error_o), 0);

    // Reset mid-operation discards stored entries and credit.
    issue_i = 1'b1;
    step();
    issue_i = 1'b0; valid_i = 1'b1; quotient_i = 8'd4; reminder_i = 8'd2;
    step();
    idle_inputs();
    chk("pre_reset.count", 32'(count_o), 1);
    do_reset();
    chk_idle("midreset");

    // Result with nothing in flight: flagged, but still stored.
    valid_i = 1'b1; quotient_i = 8'd7; reminder_i = 8'd9;
    step();
    idle_inputs();
    chk("orphan.err", 32'(error_o), 1);
    chk("orphan.count", 32'(count_o), 1);
    chk("orphan.valid", 32'(valid_o), 1);
    chk("orphan.q", 32'(quotient_o), 7);
    chk("orphan.r", 32'(reminder_o), 9);
    chk("orphan.ok", 32'(issue_ok_o), 1);
    step();
    step();
    chk("orphan.err_sticky", 32'(error_o), 1);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
